// File: rtl/rng_pkg.sv
`default_nettype none
// =============================================================================
// Module      : rng_pkg
// Description : Shared constants, register decode and helper functions for
//               the RNG AXI4-Lite peripheral.
// Revision    : 1.0 - initial release
// =============================================================================
package rng_pkg;

  // Byte offsets of the four registers
  localparam logic [3:0] OFF_CTRL    = 4'h0;
  localparam logic [3:0] OFF_SEED    = 4'h4;
  localparam logic [3:0] OFF_SCRATCH = 4'h8;
  localparam logic [3:0] OFF_RAND    = 4'hC;

  // Register select as decoded from address bits [3:2]
  typedef enum logic [1:0] {
    REG_CTRL    = OFF_CTRL[3:2],
    REG_SEED    = OFF_SEED[3:2],
    REG_SCRATCH = OFF_SCRATCH[3:2],
    REG_RAND    = OFF_RAND[3:2]
  } reg_sel_e;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_STEP_BIT = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // x^32 + x^22 + x^2 + x + 1, Galois form
  localparam logic [31:0] DEFAULT_LFSR_TAPS  = 32'h80200003;
  localparam logic [31:0] DEFAULT_RESET_SEED = 32'h00000001;

  // One Galois LFSR step: shift right, fold taps in when a 1 falls out
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur,
                                            input logic [31:0] taps);
    return (cur >> 1) ^ (cur[0] ? taps : 32'h0);
  endfunction

  // Replace only the bytes whose strobe is set
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rng_s_axi_lite_if.sv
`default_nettype none
// =============================================================================
// Module      : rng_s_axi_lite_if
// Description : AXI4-Lite channel bundle with master and slave views.
// Revision    : 1.0 - initial release
// =============================================================================
interface rng_s_axi_lite_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/rng_lfsr.sv
`default_nettype none
// =============================================================================
// Module      : rng_lfsr
// Description : 32-bit Galois LFSR with synchronous load and step. A zero
//               load value would lock the LFSR, so it is replaced by the
//               reset seed.
// Revision    : 1.0 - initial release
// =============================================================================
module rng_lfsr
  import rng_pkg::*;
#(
  parameter logic [31:0] LFSR_TAPS  = DEFAULT_LFSR_TAPS,
  parameter logic [31:0] RESET_SEED = DEFAULT_RESET_SEED
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        load,
  input  wire logic [31:0] load_val,
  input  wire logic        step,
  output logic [31:0]      state
);

  logic [31:0] r_state;

  // Load has priority over step so a seed write always lands intact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET_SEED;
    end else if (load) begin
      r_state <= (load_val == 32'h0) ? RESET_SEED : load_val;
    end else if (step) begin
      r_state <= lfsr_next(r_state, LFSR_TAPS);
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/rng_s_axi_lite.sv
`default_nettype none
// =============================================================================
// Module      : rng_s_axi_lite
// Description : AXI4-Lite responder for the RNG peripheral. Four registers
//               (CTRL, SEED, SCRATCH, RAND) and a free-running or
//               step-on-read LFSR whose state is also exported as rng_out.
// Revision    : 1.0 - initial release
// =============================================================================
module rng_s_axi_lite
  import rng_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] LFSR_TAPS          = DEFAULT_LFSR_TAPS,
  parameter logic [31:0] RESET_SEED         = DEFAULT_RESET_SEED
) (
  input  wire logic            S_AXI_ACLK,
  input  wire logic            S_AXI_ARESETN,
  rng_s_axi_lite_if.slave      s_axi,
  output logic [31:0]          rng_out
);

  // AW / W holding buffers
  logic                          r_aw_full;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_aw_addr;
  logic                          r_w_full;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_w_data;
  logic [3:0]                    r_w_strb;

  // Channel handshake state
  logic r_awready;
  logic r_wready;
  logic r_arready;
  logic r_bvalid;
  logic r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

  // Software-visible registers
  logic [1:0]  r_ctrl;
  logic [31:0] r_seed;
  logic [31:0] r_scratch;

  logic [31:0] w_lfsr;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic        w_commit;
  logic        w_aw_full_nxt;
  logic        w_w_full_nxt;
  logic        w_bvalid_nxt;
  logic        w_rvalid_nxt;
  reg_sel_e    w_wr_sel;
  reg_sel_e    w_rd_sel;
  logic [31:0] w_wr_old;
  logic [31:0] w_wr_merged;
  logic [31:0] w_rd_val;
  logic        w_lfsr_load;
  logic        w_lfsr_step;
  logic        w_unused;

  assign w_aw_hs  = s_axi.awvalid & r_awready;
  assign w_w_hs   = s_axi.wvalid  & r_wready;
  assign w_ar_hs  = s_axi.arvalid & r_arready;
  // Commit happens the edge after both halves of a write are buffered
  assign w_commit = r_aw_full & r_w_full;

  assign w_wr_sel = reg_sel_e'(r_aw_addr[3:2]);
  assign w_rd_sel = reg_sel_e'(s_axi.araddr[3:2]);

  // Next-state of buffers and VALIDs; READYs are registered from these
  always_comb begin
    w_aw_full_nxt = r_aw_full;
    w_w_full_nxt  = r_w_full;
    w_bvalid_nxt  = r_bvalid;
    w_rvalid_nxt  = r_rvalid;
    if (w_commit) begin
      w_aw_full_nxt = 1'b0;
      w_w_full_nxt  = 1'b0;
      w_bvalid_nxt  = 1'b1;
    end else begin
      if (w_aw_hs) w_aw_full_nxt = 1'b1;
      if (w_w_hs)  w_w_full_nxt  = 1'b1;
      if (r_bvalid && s_axi.bready) w_bvalid_nxt = 1'b0;
    end
    if (w_ar_hs) begin
      w_rvalid_nxt = 1'b1;
    end else if (r_rvalid && s_axi.rready) begin
      w_rvalid_nxt = 1'b0;
    end
  end

  // Current content of the write target, used for byte merging
  always_comb begin
    w_wr_old = 32'h0;
    case (w_wr_sel)
      REG_CTRL:    w_wr_old = {30'h0, r_ctrl};
      REG_SEED:    w_wr_old = r_seed;
      REG_SCRATCH: w_wr_old = r_scratch;
      default:     w_wr_old = 32'h0;
    endcase
  end

  assign w_wr_merged = byte_merge(w_wr_old, r_w_data, r_w_strb);

  // Read mux; RAND returns the pre-step LFSR value
  always_comb begin
    w_rd_val = 32'h0;
    case (w_rd_sel)
      REG_CTRL:    w_rd_val = {30'h0, r_ctrl};
      REG_SEED:    w_rd_val = r_seed;
      REG_SCRATCH: w_rd_val = r_scratch;
      REG_RAND:    w_rd_val = w_lfsr;
      default:     w_rd_val = 32'h0;
    endcase
  end

  assign w_lfsr_load = w_commit & (w_wr_sel == REG_SEED);
  assign w_lfsr_step = r_ctrl[CTRL_EN_BIT]
                     | (r_ctrl[CTRL_STEP_BIT] & w_ar_hs & (w_rd_sel == REG_RAND));

  // Write-channel buffers, B response and AW/W readiness
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= 4'h0;
      r_bvalid  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
    end else begin
      r_aw_full <= w_aw_full_nxt;
      r_w_full  <= w_w_full_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_awready <= ~w_aw_full_nxt & ~w_bvalid_nxt;
      r_wready  <= ~w_w_full_nxt  & ~w_bvalid_nxt;
      if (w_aw_hs) r_aw_addr <= s_axi.awaddr;
      if (w_w_hs) begin
        r_w_data <= s_axi.wdata;
        r_w_strb <= s_axi.wstrb;
      end
    end
  end

  // Read channel: capture on AR handshake, hold until RREADY
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_arready <= 1'b0;
    end else begin
      r_rvalid  <= w_rvalid_nxt;
      r_arready <= ~w_rvalid_nxt & ~w_ar_hs;
      if (w_ar_hs) r_rdata <= w_rd_val;
    end
  end

  // Register file update on write commit; RAND writes are dropped
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_ctrl    <= 2'b00;
      r_seed    <= 32'h0;
      r_scratch <= 32'h0;
    end else if (w_commit) begin
      case (w_wr_sel)
        REG_CTRL:    r_ctrl    <= w_wr_merged[1:0];
        REG_SEED:    r_seed    <= w_wr_merged;
        REG_SCRATCH: r_scratch <= w_wr_merged;
        default:     ;
      endcase
    end
  end

  rng_lfsr #(
    .LFSR_TAPS  (LFSR_TAPS),
    .RESET_SEED (RESET_SEED)
  ) u_lfsr (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .load     (w_lfsr_load),
    .load_val (w_wr_merged),
    .step     (w_lfsr_step),
    .state    (w_lfsr)
  );

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = RESP_OKAY;
  assign rng_out       = w_lfsr;

  // Protection bits and sub-word address bits carry no meaning here
  assign w_unused = ^{s_axi.awprot, s_axi.arprot, r_aw_addr[1:0], s_axi.araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_rng_s_axi_lite.sv
`default_nettype none
// =============================================================================
// Module      : tb_rng_s_axi_lite
// Description : Self-checking bench for rng_s_axi_lite: directed vector
//               table, hand-written timing sequences and randomized traffic
//               against a transaction-level register/LFSR model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_rng_s_axi_lite;
  import rng_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rng_out;

  always #5 clk = ~clk;

  rng_s_axi_lite_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  rng_s_axi_lite #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4),
    .LFSR_TAPS          (32'h80200003),
    .RESET_SEED         (32'h00000001)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (bus.slave),
    .rng_out       (rng_out)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [1:0]  m_ctrl;
  logic [31:0] m_seed, m_scratch, m_lfsr;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt [17];
  logic [31:0] rd, lf0, lf1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
  endfunction

  task automatic model_reset();
    m_ctrl = 2'b00; m_seed = 32'h0; m_scratch = 32'h0; m_lfsr = 32'h1;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask, t;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    case (a[3:2])
      2'd0: begin t = ({30'h0, m_ctrl} & ~mask) | (d & mask); m_ctrl = t[1:0]; end
      2'd1: begin
        m_seed = (m_seed & ~mask) | (d & mask);
        m_lfsr = (m_seed == 32'h0) ? 32'h1 : m_seed;
      end
      2'd2: m_scratch = (m_scratch & ~mask) | (d & mask);
      default: ;
    endcase
  endtask

  task automatic model_read(input logic [3:0] a, output logic [31:0] v);
    case (a[3:2])
      2'd0: v = {30'h0, m_ctrl};
      2'd1: v = m_seed;
      2'd2: v = m_scratch;
      default: begin
        v = m_lfsr;
        if (m_ctrl[1]) m_lfsr = ref_step(m_lfsr);
      end
    endcase
  endtask

  task automatic bus_idle();
    bus.awaddr = 4'h0; bus.awprot = 3'h0; bus.awvalid = 1'b0;
    bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = 4'h0; bus.arprot = 3'h0; bus.arvalid = 1'b0; bus.rready = 1'b0;
  endtask

  // Full write transaction; lfsr_b0/lfsr_b1 sample rng_out on the first two
  // cycles BVALID is observed
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int b_dly, output logic [31:0] lfsr_b0,
                          output logic [31:0] lfsr_b1);
    int n;
    lfsr_b0 = 32'h0;
    lfsr_b1 = 32'h0;
    fork
      begin
        int k;
        repeat (aw_dly) @(negedge clk);
        bus.awaddr = addr; bus.awprot = 3'($urandom); bus.awvalid = 1'b1;
        k = 0;
        while (!bus.awready && k < 50) begin @(negedge clk); k++; end
        if (!bus.awready) timeout_fail("aw_timeout");
        else @(negedge clk);
        bus.awvalid = 1'b0;
      end
      begin
        int k;
        repeat (w_dly) @(negedge clk);
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        k = 0;
        while (!bus.wready && k < 50) begin @(negedge clk); k++; end
        if (!bus.wready) timeout_fail("w_timeout");
        else @(negedge clk);
        bus.wvalid = 1'b0;
      end
    join
    n = 0;
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bus.bvalid) begin
      timeout_fail("b_timeout");
    end else begin
      lfsr_b0 = rng_out;
      chk("bresp", {30'h0, bus.bresp}, 32'h0);
      @(negedge clk);
      lfsr_b1 = rng_out;
      repeat (b_dly - 1) @(negedge clk);
      chk("bvalid_hold", {31'h0, bus.bvalid}, 32'h1);
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      chk("bvalid_clear", {31'h0, bus.bvalid}, 32'h0);
    end
    model_write(addr, data, strb);
    if (!m_ctrl[0]) chk("rng_out_after_wr", rng_out, m_lfsr);
  endtask

  // Full read transaction, checked against the model
  task automatic do_read(input logic [3:0] addr, input int ar_dly, input int r_dly,
                         output logic [31:0] data);
    int n;
    logic [31:0] exp;
    data = 32'h0;
    repeat (ar_dly) @(negedge clk);
    bus.araddr = addr; bus.arprot = 3'($urandom); bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    if (!bus.arready) begin
      timeout_fail("ar_timeout");
      bus.arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    model_read(addr, exp);
    chk("rvalid", {31'h0, bus.rvalid}, 32'h1);
    chk("rresp", {30'h0, bus.rresp}, 32'h0);
    chk("rdata", bus.rdata, exp);
    data = bus.rdata;
    repeat (r_dly) @(negedge clk);
    if (r_dly > 0) chk("rdata_hold", bus.rdata, exp);
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    chk("rvalid_clear", {31'h0, bus.rvalid}, 32'h0);
    if (!m_ctrl[0]) chk("rng_out_after_rd", rng_out, m_lfsr);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed vectors: rd entries carry a fixed expected read value
    vt[0]  = '{1'b0, 4'hC, 32'h0,        4'hF, 32'h00000001};
    vt[1]  = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h00000000};
    vt[2]  = '{1'b1, 4'h4, 32'h00000001, 4'hF, 32'h0};
    vt[3]  = '{1'b1, 4'h0, 32'h00000002, 4'hF, 32'h0};
    vt[4]  = '{1'b0, 4'hC, 32'h0,        4'hF, 32'h00000001};
    vt[5]  = '{1'b0, 4'hC, 32'h0,        4'hF, 32'h80200003};
    vt[6]  = '{1'b0, 4'hC, 32'h0,        4'hF, 32'hC0300002};
    vt[7]  = '{1'b1, 4'h8, 32'hA5A5A5A5, 4'hF, 32'h0};
    vt[8]  = '{1'b1, 4'h8, 32'h000000FF, 4'h1, 32'h0};
    vt[9]  = '{1'b0, 4'h8, 32'h0,        4'hF, 32'hA5A5A5FF};
    vt[10] = '{1'b1, 4'h4, 32'h00000000, 4'hF, 32'h0};
    vt[11] = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h00000000};
    vt[12] = '{1'b0, 4'hC, 32'h0,        4'hF, 32'h00000001};
    vt[13] = '{1'b1, 4'hC, 32'h12345678, 4'hF, 32'h0};
    vt[14] = '{1'b0, 4'hC, 32'h0,        4'hF, 32'h80200003};
    vt[15] = '{1'b1, 4'h0, 32'h00000000, 4'hF, 32'h0};
    vt[16] = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h00000000};

    bus_idle();
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_awready", {31'h0, bus.awready}, 32'h0);
    chk("rst_bvalid", {31'h0, bus.bvalid}, 32'h0);
    chk("rst_rvalid", {31'h0, bus.rvalid}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_rng_out", rng_out, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {29'h0, bus.awready, bus.wready, bus.arready}, 32'h7);

    // Table-driven directed part
    for (int i = 0; i < 17; i++) begin
      if (vt[i].wr) begin
        do_write(vt[i].addr, vt[i].data, vt[i].strb, 0, 0, 1, lf0, lf1);
      end else begin
        do_read(vt[i].addr, 0, 1, rd);
        chk($sformatf("vec%0d", i), rd, vt[i].exp);
      end
    end

    // AW early, W three cycles later, BREADY held low for four cycles
    bus.awaddr = 4'h8; bus.awvalid = 1'b1;
    chk("t4_awready0", {31'h0, bus.awready}, 32'h1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    chk("t4_aw_blocked1", {31'h0, bus.awready}, 32'h0);
    @(negedge clk);
    chk("t4_aw_blocked2", {31'h0, bus.awready}, 32'h0);
    @(negedge clk);
    bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    chk("t4_wready", {31'h0, bus.wready}, 32'h1);
    @(negedge clk);
    bus.wvalid = 1'b0;
    chk("t4_bvalid_early", {31'h0, bus.bvalid}, 32'h0);
    @(negedge clk);
    chk("t4_bvalid_rise", {31'h0, bus.bvalid}, 32'h1);
    chk("t4_bresp", {30'h0, bus.bresp}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_b_hold", {30'h0, bus.bvalid, bus.awready}, 32'h2);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    chk("t4_b_done", {30'h0, bus.bvalid, bus.awready}, 32'h1);
    model_write(4'h8, 32'h0BADF00D, 4'hF);
    do_read(4'h8, 0, 0, rd);

    // Randomized traffic, free-run kept off so timing is model-independent
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  a;
      logic [31:0] d;
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        if (a[3:2] == 2'd1 && $urandom_range(0, 3) == 0) d = 32'h0;
        if (a[3:2] == 2'd0) d[0] = 1'b0;
        do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(1, 3), lf0, lf1);
      end else begin
        do_read(a, $urandom_range(0, 2), $urandom_range(0, 3), rd);
      end
    end

    // Free-run on, then a seed write: the seed beats that cycle's step
    do_write(4'h0, 32'h00000001, 4'hF, 0, 0, 1, lf0, lf1);
    do_write(4'h4, 32'hDEADBEEF, 4'hF, 1, 0, 2, lf0, lf1);
    chk("seed_wins", lf0, 32'hDEADBEEF);
    chk("freerun_step", lf1, ref_step(32'hDEADBEEF));

    // Reset with a read response pending
    bus.araddr = 4'h0; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    chk("t6_rvalid", {31'h0, bus.rvalid}, 32'h1);
    chk("t6_rdata", bus.rdata, 32'h00000001);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rvalid_rst", {31'h0, bus.rvalid}, 32'h0);
    chk("t6_lfsr_rst", rng_out, 32'h1);
    chk("t6_ready_rst", {29'h0, bus.awready, bus.wready, bus.arready}, 32'h0);
    bus_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(4'h0, 0, 0, rd);
    chk("t6_ctrl", rd, 32'h0);
    do_read(4'hC, 0, 1, rd);
    chk("t6_rand", rd, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
